// File: rtl/step_clk_pkg.sv
// Shared mode encoding and default sizing for the stepped clock generator.
package step_clk_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned          CNT_W_DEF   = 28;
  localparam logic [CNT_W_DEF-1:0] RST_DIV_DEF = 28'd11999999;

endpackage

// File: rtl/step_clk_gen_if.sv
// Control/status bundle of the stepped clock generator: per-channel
// enables, modes, divider load strobes and the divided outputs.
interface step_clk_gen_if
  import step_clk_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic [N_CH-1:0]       i_EN;
  logic [N_CH-1:0]       i_MODE;
  logic [N_CH*CNT_W-1:0] i_DIV;
  logic [N_CH-1:0]       i_LOAD;
  logic [N_CH-1:0]       o_CLK;
  logic [N_CH-1:0]       o_TICK;
  logic [N_CH-1:0]       o_PEND;

  modport master (
    output i_EN, i_MODE, i_DIV, i_LOAD,
    input  o_CLK, o_TICK, o_PEND
  );

  modport slave (
    input  i_EN, i_MODE, i_DIV, i_LOAD,
    output o_CLK, o_TICK, o_PEND
  );

endinterface

// File: rtl/step_clk_chan.sv
// One divider channel: up-counter to the active divider with a shadow
// divider that is swapped in only at terminal count to avoid glitched periods.
module step_clk_chan
  import step_clk_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = RST_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div,
  input  logic             load,
  output logic             div_clk,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
  logic [CNT_W-1:0] div_r,    div_nxt_s;
  logic [CNT_W-1:0] shadow_r, shadow_nxt_s;
  logic             pend_r,   pend_nxt_s;
  mode_e            mode_r,   mode_nxt_s;
  logic             clk_r,    clk_nxt_s;
  logic             tick_r,   tick_nxt_s;
  logic             tc_s;

  // Terminal count only exists while running; a disabled counter sits at zero.
  assign tc_s = en && (cnt_r == div_r);

  // Next-state logic for counter, dividers, mode latch and outputs.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    div_nxt_s    = div_r;
    shadow_nxt_s = shadow_r;
    pend_nxt_s   = pend_r;
    mode_nxt_s   = mode_r;
    clk_nxt_s    = clk_r;
    tick_nxt_s   = 1'b0;
    if (!en) begin
      // Idle: mode is transparent and any divider update takes effect at once.
      cnt_nxt_s  = CNT_ZERO;
      clk_nxt_s  = 1'b0;
      tick_nxt_s = 1'b0;
      mode_nxt_s = mode_e'(mode);
      pend_nxt_s = 1'b0;
      if (load) begin
        div_nxt_s = div;
      end else if (pend_r) begin
        div_nxt_s = shadow_r;
      end else begin
        div_nxt_s = div_r;
      end
    end else begin
      tick_nxt_s = tc_s;
      if (tc_s) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
      case (mode_r)
        MODE_TOGGLE: clk_nxt_s = clk_r ^ tc_s;
        MODE_PULSE:  clk_nxt_s = tc_s;
        default:     clk_nxt_s = 1'b0;
      endcase
      // A load on the boundary cycle can go straight into the active divider.
      if (load && !tc_s) begin
        shadow_nxt_s = div;
        pend_nxt_s   = 1'b1;
      end else if (load) begin
        div_nxt_s  = div;
        pend_nxt_s = 1'b0;
      end else if (tc_s && pend_r) begin
        div_nxt_s  = shadow_r;
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = pend_r;
      end
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      div_r    <= RST_DIV;
      shadow_r <= RST_DIV;
      pend_r   <= 1'b0;
      mode_r   <= MODE_TOGGLE;
      clk_r    <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      div_r    <= div_nxt_s;
      shadow_r <= shadow_nxt_s;
      pend_r   <= pend_nxt_s;
      mode_r   <= mode_nxt_s;
      clk_r    <= clk_nxt_s;
      tick_r   <= tick_nxt_s;
    end
  end

  assign div_clk = clk_r;
  assign tick    = tick_r;
  assign pend    = pend_r;

endmodule

// File: rtl/step_clk_gen.sv
// N_CH independent programmable clock/pulse dividers running off one
// system clock; each channel is a step_clk_chan instance.
module step_clk_gen
  import step_clk_pkg::*;
#(
  parameter int unsigned      N_CH    = 4,
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = 28'd11999999
) (
  input logic           n_CLK,
  input logic           n_RST,
  step_clk_gen_if.slave bus
);

  logic [N_CH-1:0] clk_s;
  logic [N_CH-1:0] tick_s;
  logic [N_CH-1:0] pend_s;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_chan
      step_clk_chan #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
      ) u_chan (
        .clk     (n_CLK),
        .rst     (n_RST),
        .en      (bus.i_EN[k]),
        .mode    (bus.i_MODE[k]),
        .div     (bus.i_DIV[k*CNT_W +: CNT_W]),
        .load    (bus.i_LOAD[k]),
        .div_clk (clk_s[k]),
        .tick    (tick_s[k]),
        .pend    (pend_s[k])
      );
    end
  endgenerate

  assign bus.o_CLK  = clk_s;
  assign bus.o_TICK = tick_s;
  assign bus.o_PEND = pend_s;

endmodule

// File: doc/step_clk_gen.md
STEP_CLK_GEN -- requirements
Module: step_clk_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 28: counter and divider width in bits.
REQ-003 Parameter RST_DIV, default 28'd11999999: divider value loaded on reset (1 Hz toggle output at 24 MHz).
REQ-004 n_CLK  input  1: the single system clock; all state updates on its rising edge.
REQ-005 n_RST  input  1: reset, synchronous and active-high.
REQ-006 i_EN  input  N_CH: per-channel run enable.
REQ-007 i_MODE  input  N_CH: per-channel mode; 0 = toggle (50% duty), 1 = pulse (one-cycle high).
REQ-008 i_DIV  input  N_CH*CNT_W: per-channel divider values; channel k uses bits [k*CNT_W +: CNT_W].
REQ-009 i_LOAD  input  N_CH: per-channel one-cycle strobe that captures the channel's i_DIV slice.
REQ-010 o_CLK  output  N_CH: registered divided clock or pulse train per channel.
REQ-011 o_TICK  output  N_CH: one-cycle registered strobe at each channel terminal count.
REQ-012 o_PEND  output  N_CH: high while a loaded divider waits to become active.

Function
REQ-013 Each channel SHALL hold an active divider D, a shadow divider, a pending flag, a latched mode and a CNT_W-bit counter.
REQ-014 While enabled, the counter SHALL increment every cycle and return to 0 at terminal count, where counter == D.
REQ-015 Toggle mode SHALL invert o_CLK on the cycle after terminal count, giving a period of 2*(D+1) cycles.
REQ-016 Pulse mode SHALL drive o_CLK high for exactly the one cycle after terminal count, giving a period of D+1 cycles.
REQ-017 D = 0 SHALL toggle o_CLK every cycle in toggle mode and hold o_CLK high continuously in pulse mode.
REQ-018 o_TICK SHALL be high for one cycle, aligned with each o_CLK update caused by terminal count, in both modes.
REQ-019 i_LOAD high with no terminal count in the same cycle SHALL write i_DIV to the shadow divider and set o_PEND the next cycle.
REQ-020 At terminal count with pending set and no i_LOAD, the shadow divider SHALL become D and o_PEND SHALL clear; the new period starts from counter 0.
REQ-021 i_LOAD in the same cycle as terminal count SHALL write i_DIV directly to D and leave o_PEND at 0.
REQ-022 A repeated i_LOAD while pending SHALL overwrite the shadow value; only the last value is applied.
REQ-023 i_LOAD while the channel is disabled SHALL write D directly and leave o_PEND at 0.
REQ-024 i_EN low SHALL hold the counter at 0, force o_CLK and o_TICK to 0 from the next cycle, and clear o_PEND after applying the shadow value to D.
REQ-025 The latched mode SHALL follow i_MODE only while i_EN is low; i_MODE changes while enabled are ignored.
REQ-026 When i_EN rises, counting SHALL start at 0, and the first terminal count SHALL occur D+1 cycles later.
REQ-027 Channels SHALL be fully independent; no input of channel k affects any other channel.
REQ-028 The counter SHALL never exceed D, so no wrap-around occurs; D = 2^CNT_W-1 is legal.

Reset
REQ-029 When n_RST is high at a clock edge, every channel SHALL set counter = 0, D = shadow = RST_DIV, o_PEND = 0, latched mode = 0, o_CLK = 0 and o_TICK = 0.
REQ-030 Reset SHALL override i_EN, i_LOAD and terminal count in the same cycle, including in the middle of a period or while a load is pending.

Structure
REQ-031 Shared package step_clk_pkg SHALL hold MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1 and the default CNT_W.
REQ-032 Single-channel logic SHALL live in sub-module step_clk_chan, instantiated N_CH times by a generate loop in step_clk_gen.

Verification
REQ-033 Reset, then ch0 enabled in toggle mode with D = 3 -> o_CLK period 8 cycles, 4 high / 4 low; o_TICK every 4 cycles.
REQ-034 ch1 in pulse mode with D = 4 -> o_CLK high 1 cycle in every 5; D = 0 -> o_CLK held high.
REQ-035 ch0 running at D = 9 with i_LOAD of 2 at counter = 5 -> o_PEND high until the next terminal count, then period 6 cycles with no short or long half-period.
REQ-036 i_LOAD of 7 on the exact terminal-count cycle -> o_PEND stays 0 and the next half-period is 8 cycles.
REQ-037 n_RST asserted mid-period with a load pending -> next cycle all outputs 0 and D = RST_DIV; ch2/ch3 unaffected by ch0/ch1 stimulus before reset.
REQ-038 i_MODE toggled while enabled -> no behaviour change; after i_EN low then high -> new mode active with first terminal count at D+1 cycles.
